// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop rx synchronizer, oversampled mid-bit sampling, LSB-first data, valid/ready output.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  parity_err
);
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [1:0]            sync_q, sync_d;
  logic [2:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
  logic [DIV_WIDTH-1:0]  div_l_q, div_l_d;
  logic [SW-1:0]         samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  armed_q, armed_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  parity_err_q, parity_err_d;
`endif
  logic                  rx_s;
  logic                  tick;
  logic                  load;

  assign rx_s = sync_q[1];
  assign tick = (tick_cnt_q == div_l_q);

  always_comb begin
    sync_d        = {sync_q[0], rx};
    state_d       = state_q;
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    div_l_d       = div_l_q;
    samp_cnt_d    = samp_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    armed_d       = armed_q;
    pend_d        = 1'b0;
    frame_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        // After a framing error the line must return high before a new start is accepted.
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          div_l_d   = baud_div;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (samp_cnt_q == MID_CNT) begin
            samp_cnt_d = '0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (samp_cnt_q == LAST_CNT) begin
            samp_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (samp_cnt_q == LAST_CNT) begin
            samp_cnt_d = '0;
            par_d      = rx_s;
            state_d    = S_STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (samp_cnt_q == LAST_CNT) begin
            samp_cnt_d = '0;
            state_d    = S_IDLE;
            if (!rx_s) begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_q}) begin
              parity_err_d = 1'b1;
`endif
            end else begin
              pend_d = 1'b1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shift_q is untouched until the next frame's DATA state, so the pending byte is read from it directly.
  always_comb begin
    load          = pend_q && (!rx_valid_q || rx_ready);
    overrun_err_d = pend_q && rx_valid_q && !rx_ready;
    rx_data_d     = load ? shift_q : rx_data_q;
    if (load)                         rx_valid_d = 1'b1;
    else if (rx_valid_q && rx_ready)  rx_valid_d = 1'b0;
    else                              rx_valid_d = rx_valid_q;
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      sync_q        <= '1;
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      div_l_q       <= '0;
      samp_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      armed_q       <= 1'b1;
      pend_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      div_l_q       <= div_l_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      pend_q        <= pend_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Synthesizable UART receiver. It is the receiving end for the serial stream the device agent BFM drives on intf.tx.
- Oversamples rx, validates the start bit and deserializes LSB-first data.
- Checks the stop bit (and parity, when compiled in) and presents each byte on a valid/ready handshake.
- Replaces the tx-to-rx loopback in hdl_top as the first real DUT attached to uart_if.

Parameters:
- DATA_WIDTH, 8: data bits per frame (5..9).
- OVERSAMPLE, 16: ticks per bit period; must be even and >= 4.
- DIV_WIDTH, 16: width of the baud divisor input.

Ports:
- pclk  input  1  system clock.
- areset  input  1  reset; synchronous, active-high.
- baud_div  input  DIV_WIDTH  pclk cycles per oversample tick, minus 1.
- rx  input  1  serial line, idle high, asynchronous to pclk.
- rx_data  output  DATA_WIDTH  received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun_err  output  1  one-cycle pulse: a new byte was dropped.
- parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset (areset=1 at posedge pclk):
  - All outputs 0, rx_data = 0.
  - Synchronizer flops = 1, tick/sample/bit counters = 0, state = IDLE, armed = 1.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Input sync: 2-flop synchronizer. rx_s is the second flop and is the only version of rx used.
- Tick generator:
  - Counter runs 0..div_l. tick = 1 on the cycle the count equals div_l, then the counter reloads to 0.
  - div_l is baud_div latched at start detection. baud_div changes mid-frame take effect on the next frame.
  - baud_div = 0 gives a tick every cycle.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: if armed and rx_s == 0, latch div_l, clear the tick and sample counters, go to START. If armed == 0, wait for rx_s == 1, then set armed = 1.
  - START: on the tick where sample count reaches OVERSAMPLE/2-1 (mid start bit):
    - rx_s == 1: glitch, return to IDLE, no error.
    - Otherwise clear the sample count and go to DATA.
  - DATA: sample rx_s every OVERSAMPLE ticks (mid-bit) and shift LSB-first. After DATA_WIDTH bits, go to PARITY if enabled, else STOP.
  - PARITY: sample once after OVERSAMPLE ticks, then go to STOP.
  - STOP: sample after OVERSAMPLE ticks (mid stop bit), then return to IDLE on the same edge. Outcome:
    - rx_s == 0: pulse frame_err, discard the byte, set armed = 0.
    - Parity mismatch: pulse parity_err, discard the byte.
    - Otherwise deliver the byte.
- Delivery, registered 1 cycle after the mid-stop sample:
  - rx_valid == 0, or rx_valid && rx_ready in this cycle: load rx_data, rx_valid = 1.
  - rx_valid == 1 && rx_ready == 0: keep the old byte, pulse overrun_err, drop the new byte.
- Handshake:
  - Transfer occurs when rx_valid && rx_ready at posedge.
  - rx_valid clears the next cycle unless a new byte loads on the same edge; in that case it stays 1 with the new rx_data.
  - rx_data is stable while rx_valid == 1.
- Latency: with baud_div = 0 and OVERSAMPLE = 16, rx_valid rises 155 ±2 pclk cycles after the rx falling edge.
- Error pulses never coincide with rx_valid loading for the same frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is present and one parity bit follows the data.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - A mismatch pulses parity_err and discards the byte.
- Undefined:
  - The PARITY state and parity logic are absent.
  - DATA goes directly to STOP.
  - The parity_err port is still present and tied to 0.

Test Plan:
- Basic byte (baud_div = 0, rx_ready = 1): send 0xA5 with stop = 1 -> rx_data = 0xA5, rx_valid high for 1 cycle, ~155 cycles after the start edge; no error pulses.
- Divider (baud_div = 3): send back-to-back 0x00 then 0xFF -> both bytes delivered in order; bit period = 64 cycles.
- Glitch: rx low for 4 cycles, then high -> return to IDLE; no rx_valid, no errors. A following 0x3C is received correctly.
- Framing (rx_ready = 1): send 0x55 with stop = 0 and hold rx low 40 bit-times -> one frame_err pulse, no rx_valid. No new start is detected until rx rises; the next 0x81 is received.
- Overrun: rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun_err pulse. Then rx_ready = 1 -> 0x11 accepted and rx_valid drops. Simultaneous ready on the load edge -> no overrun.
- Parity/reset (UART_RX_PARITY_EN): send 0x07 with parity bit 0 -> one parity_err pulse, byte dropped. Assert areset in mid DATA -> all outputs 0 and state IDLE on the next cycle; a subsequent 0x07 with parity bit 1 is received.
